// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle RV32I core: byte-enabled RAM with
// combinational extended loads, plus a 4-register MMIO window (LED, CYCLE, STATUS, FAULT_ADDR).
module dmem_responder #(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] Wr_mem_data,
  output logic [31:0] Rd_mem_data,
  output logic        misalign,
  output logic [15:0] led_out
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_led;
  logic [31:0] r_cycle;
  logic [1:0]  r_status;
  logic [31:0] r_faultAddr;

  logic              w_isMmio;
  logic              w_active;
  logic              w_ldOk;
  logic              w_stOk;
  logic              w_legal;
  logic              w_badAlign;
  logic              w_ok;
  logic              w_ramWe;
  logic              w_ioWe;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_ramWord;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  assign w_isMmio = (addr[31:4] == IO_BASE[31:4]);
  assign w_active = MemRead | MemWrite;
  assign w_idx    = addr[ADDR_W+1:2];

  // MMIO only accepts word accesses; narrower sizes there count as illegal.
  always_comb begin
    w_ldOk = 1'b0;
    case (func3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ldOk = 1'b1;
      default:                                w_ldOk = 1'b0;
    endcase
    w_stOk     = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    w_legal    = (!MemRead || w_ldOk) && (!MemWrite || w_stOk) &&
                 (!w_isMmio || func3 == 3'b010);
    w_badAlign = ((func3[1:0] == 2'b01) && addr[0]) ||
                 ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  assign w_ok     = w_legal & ~w_badAlign;
  assign misalign = w_active & w_legal & w_badAlign;
  assign w_ramWe  = MemWrite & w_ok & ~w_isMmio & ~rst;
  assign w_ioWe   = MemWrite & w_ok & w_isMmio;
  assign w_set    = {w_active & ~w_legal, misalign};
  assign w_clr    = (w_ioWe && addr[3:2] == 2'b10) ? Wr_mem_data[1:0] : 2'b00;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = Wr_mem_data;
    case (func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{Wr_mem_data[7:0]}};
      end
      2'b01: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{Wr_mem_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = Wr_mem_data;
      end
    endcase
  end

  // RAM has no reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (w_ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // A set event beats a simultaneous W1C; FAULT_ADDR latches only the first fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led       <= '0;
      r_cycle     <= '0;
      r_status    <= '0;
      r_faultAddr <= '0;
    end else begin
      r_cycle  <= r_cycle + 32'd1;
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_ioWe && addr[3:2] == 2'b00) r_led <= Wr_mem_data;
      if ((|w_set) && (r_status == 2'b00)) r_faultAddr <= addr;
    end
  end

  assign led_out   = r_led[15:0];
  assign w_ramWord = r_mem[w_idx];

  always_comb begin
    w_byte = w_ramWord[7:0];
    case (addr[1:0])
      2'b00:   w_byte = w_ramWord[7:0];
      2'b01:   w_byte = w_ramWord[15:8];
      2'b10:   w_byte = w_ramWord[23:16];
      default: w_byte = w_ramWord[31:24];
    endcase
    w_half = addr[1] ? w_ramWord[31:16] : w_ramWord[15:0];
  end

  always_comb begin
    Rd_mem_data = '0;
    if (MemRead && w_ok) begin
      if (w_isMmio) begin
        case (addr[3:2])
          2'b00:   Rd_mem_data = r_led;
          2'b01:   Rd_mem_data = r_cycle;
          2'b10:   Rd_mem_data = {30'b0, r_status};
          default: Rd_mem_data = r_faultAddr;
        endcase
      end else begin
        case (func3)
          3'b000:  Rd_mem_data = {{24{w_byte[7]}}, w_byte};
          3'b001:  Rd_mem_data = {{16{w_half[15]}}, w_half};
          3'b100:  Rd_mem_data = {24'b0, w_byte};
          3'b101:  Rd_mem_data = {16'b0, w_half};
          default: Rd_mem_data = w_ramWord;
        endcase
      end
    end
  end

endmodule
